// File: rtl/seg_scan_mux_if.sv
// Bus between the segment decoders and the 7-segment scan driver.
//   seg_in      : packed 7-bit patterns, digit 0 in the low bits, 1 = segment lit
//   load        : capture seg_in into the shadow buffer
//   enable      : 1 = scan, 0 = display dark with the scan parked
//   an          : registered digit anode selects
//   seg_out     : registered segment lines for the selected digit
//   dig_idx     : digit currently selected or about to be selected
//   frame_start : one-cycle pulse at every frame boundary
//   pending     : shadow buffer holds data not yet shown
// master = pattern source side, slave = scan driver side.
interface seg_scan_mux_if #(
  parameter int N_DIGITS = 4
);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [7*N_DIGITS-1:0] seg_in;
  logic                  load;
  logic                  enable;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg_out;
  logic [IW-1:0]         dig_idx;
  logic                  frame_start;
  logic                  pending;

  modport master (
    output seg_in, load, enable,
    input  an, seg_out, dig_idx, frame_start, pending
  );

  modport slave (
    input  seg_in, load, enable,
    output an, seg_out, dig_idx, frame_start, pending
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan driver for a multi-digit 7-segment display.
// Patterns are captured into a shadow buffer on load and copied to the active
// buffer only at a frame boundary, so a frame never mixes old and new data.
// Each digit is preceded by a blanking gap (all anodes off) to stop ghosting.
// Ports:
//   clk : system clock
//   rst : synchronous reset, active-high
//   bus : seg_scan_mux_if.slave (seg_in, load, enable in; an, seg_out,
//         dig_idx, frame_start, pending out, all outputs registered)
module seg_scan_mux #(
  parameter int N_DIGITS         = 4,
  parameter int DIGIT_CYCLES     = 50000,
  parameter int BLANK_CYCLES     = 1000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 0
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_mux_if.slave  bus
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int CMAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - 1);
  // BLANK_CYCLES of 0 or 1 both give a single blank cycle.
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 1) ? (BLANK_CYCLES - 1) : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  // XOR masks: an inactive anode / unlit segment in output polarity.
  localparam logic [N_DIGITS-1:0] AN_OFF  = (ANODE_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [CW-1:0]         cnt_r, cnt_nxt_s;
  logic [IW-1:0]         idx_r, idx_nxt_s;
  logic [7*N_DIGITS-1:0] shadow_r, shadow_nxt_s;
  logic [7*N_DIGITS-1:0] active_r, active_nxt_s;
  logic                  pending_r, pending_nxt_s;
  logic                  en_prev_r;
  logic [N_DIGITS-1:0]   an_r, an_nxt_s;
  logic [6:0]            seg_r, seg_nxt_s;
  logic                  fs_r;
  logic                  wrap_s;
  logic                  fb_s;
  logic [N_DIGITS-1:0]   onehot_s;
  logic [6:0]            sel_s;

  // Frame boundary: leaving the last digit's DRIVE, or first enabled edge
  // after reset / after the scan was parked.
  assign wrap_s = (state_r == ST_DRIVE) && (cnt_r == DRIVE_LAST) && (idx_r == IDX_LAST);
  assign fb_s   = bus.enable && (!en_prev_r || wrap_s);

  // Next-state, buffer and output decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    idx_nxt_s     = idx_r;
    shadow_nxt_s  = shadow_r;
    active_nxt_s  = active_r;
    pending_nxt_s = pending_r;
    onehot_s      = {N_DIGITS{1'b0}};
    sel_s         = 7'h00;
    an_nxt_s      = AN_OFF;
    seg_nxt_s     = SEG_OFF;

    if (!bus.enable) begin
      state_nxt_s = ST_BLANK;
      cnt_nxt_s   = {CW{1'b0}};
      idx_nxt_s   = {IW{1'b0}};
    end else begin
      case (state_r)
        ST_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_nxt_s = ST_DRIVE;
            cnt_nxt_s   = {CW{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CW'(1'b1);
          end
        end
        ST_DRIVE: begin
          if (cnt_r == DRIVE_LAST) begin
            state_nxt_s = ST_BLANK;
            cnt_nxt_s   = {CW{1'b0}};
            if (idx_r == IDX_LAST) begin
              idx_nxt_s = {IW{1'b0}};
            end else begin
              idx_nxt_s = idx_r + IW'(1'b1);
            end
          end else begin
            cnt_nxt_s = cnt_r + CW'(1'b1);
          end
        end
        default: begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = {CW{1'b0}};
          idx_nxt_s   = {IW{1'b0}};
        end
      endcase
    end

    // The transfer uses the shadow as it was before this edge, so a load on
    // the boundary edge is kept pending for the following frame.
    if (fb_s && pending_r) begin
      active_nxt_s = shadow_r;
    end else begin
      active_nxt_s = active_r;
    end

    if (bus.load) begin
      shadow_nxt_s  = bus.seg_in;
      pending_nxt_s = 1'b1;
    end else if (fb_s) begin
      shadow_nxt_s  = shadow_r;
      pending_nxt_s = 1'b0;
    end else begin
      shadow_nxt_s  = shadow_r;
      pending_nxt_s = pending_r;
    end

    for (int i = 0; i < N_DIGITS; i++) begin
      onehot_s[i] = (idx_nxt_s == IW'(i));
    end
    // Next-state values so a digit entered on a boundary edge shows the
    // freshly transferred data.
    sel_s = active_nxt_s[32'd7 * 32'(idx_nxt_s) +: 7];

    if (state_nxt_s == ST_DRIVE) begin
      an_nxt_s  = onehot_s ^ AN_OFF;
      seg_nxt_s = sel_s ^ SEG_OFF;
    end else begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
    end
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_BLANK;
      cnt_r     <= {CW{1'b0}};
      idx_r     <= {IW{1'b0}};
      shadow_r  <= {(7*N_DIGITS){1'b0}};
      active_r  <= {(7*N_DIGITS){1'b0}};
      pending_r <= 1'b0;
      en_prev_r <= 1'b0;
      an_r      <= AN_OFF;
      seg_r     <= SEG_OFF;
      fs_r      <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      idx_r     <= idx_nxt_s;
      shadow_r  <= shadow_nxt_s;
      active_r  <= active_nxt_s;
      pending_r <= pending_nxt_s;
      en_prev_r <= bus.enable;
      an_r      <= an_nxt_s;
      seg_r     <= seg_nxt_s;
      fs_r      <= fb_s;
    end
  end

  assign bus.an          = an_r;
  assign bus.seg_out     = seg_r;
  assign bus.dig_idx     = idx_r;
  assign bus.frame_start = fs_r;
  assign bus.pending     = pending_r;

endmodule
